pipe_ctrl_gen: RTL and testbench

Parametrised pipeline hazard and exception controller for the core's in-order pipeline; successor to the fixed six-stage stall/flush controller. Generates per-stage stall and bubble vectors from any number of stage stall requests, sequences a multi-cycle flush with a one-cycle PC redirect, and defers an exception raised during a global freeze until the freeze lifts. Sits beside the stage registers and the PC unit, fed by CP0 and the MEM-stage exception resolver.

---
 rtl/pipe_ctrl_gen_pkg.sv | 20 ++
 rtl/pipe_ctrl_gen_stall_vector_gen.sv | 46 ++++
 rtl/pipe_ctrl_gen.sv | 120 ++++++++++++
 tb/tb_pipe_ctrl_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_gen_pkg.sv
// ============================================================================
// pipe_ctrl_gen_pkg : shared constants for the pipeline hazard/exception controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_gen_pkg;

    localparam logic [3:0]  EXC_NULL_CODE   = 4'd0;
    localparam logic [3:0]  EXC_ERET_CODE   = 4'd1;
    localparam logic [31:0] INIT_PC_VAL     = 32'hbfc00000;
    localparam logic [31:0] EXC_OFFSET_VAL  = 32'h180;

    localparam logic [1:0]  ST_IDLE  = 2'b00;
    localparam logic [1:0]  ST_PEND  = 2'b01;
    localparam logic [1:0]  ST_FLUSH = 2'b10;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_gen_stall_vector_gen.sv
// ============================================================================
// stall_vector_gen : priority-thermometer encoder turning stall requests into
//                    per-stage stall and bubble vectors (STAGES >= 2)
// Revision: 1.0
// ============================================================================
`default_nettype none

module stall_vector_gen #(
    parameter int STAGES = 6
) (
    input  logic [STAGES-1:0] stall_req,
    input  logic              stall_all,
    input  logic              flush,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] bubble
);

    logic [STAGES-1:0] w_therm;
    logic              w_acc;

    // Every stage at or below the highest requester must hold.
    always_comb begin
        w_acc   = 1'b0;
        w_therm = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_acc      = w_acc | stall_req[i];
            w_therm[i] = w_acc;
        end
    end

    always_comb begin
        stall  = '0;
        bubble = '0;
        if (stall_all) begin
            stall = '1;
        end else if (!flush) begin
            stall = w_therm;
        end
        if (!flush) begin
            bubble = {stall[STAGES-2:0] & ~stall[STAGES-1:1], 1'b0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl_gen.sv
// ============================================================================
// pipe_ctrl_gen : pipeline stall/bubble generation, flush sequencing with PC
//                 redirect, and exception deferral across global freezes
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl_gen
    import pipe_ctrl_gen_pkg::*;
#(
    parameter int                STAGES     = 6,
    parameter int                ADDR_W     = 32,
    parameter int                EXC_W      = 4,
    parameter logic [EXC_W-1:0]  EXC_NULL   = EXC_W'(EXC_NULL_CODE),
    parameter logic [EXC_W-1:0]  EXC_ERET   = EXC_W'(EXC_ERET_CODE),
    parameter int                FLUSH_LEN  = 1,
    parameter logic [ADDR_W-1:0] INIT_PC    = ADDR_W'(INIT_PC_VAL),
    parameter logic [ADDR_W-1:0] EXC_OFFSET = ADDR_W'(EXC_OFFSET_VAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stall_req,
    input  logic              stall_all,
    input  logic [EXC_W-1:0]  exception_type,
    input  logic [ADDR_W-1:0] cp0_epc,
    input  logic [ADDR_W-1:0] exc_base,
    input  logic              perf_clr,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] bubble,
    output logic              flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              exc_pending,
    output logic [31:0]       stall_cycles
);

    localparam int CNT_W = $clog2(FLUSH_LEN + 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_target;
    logic [ADDR_W-1:0] r_last_pc;
    logic [31:0]       r_stall_cycles;

    logic              w_exc_valid;
    logic              w_accept;
    logic [ADDR_W-1:0] w_new_target;
    logic [ADDR_W-1:0] w_accept_target;

    assign w_exc_valid     = (exception_type != EXC_NULL);
    assign w_new_target    = (exception_type == EXC_ERET) ? cp0_epc : (exc_base + EXC_OFFSET);
    assign w_accept        = !stall_all && (((r_state == ST_IDLE) && w_exc_valid) || (r_state == ST_PEND));
    // A deferred exception redirects to the target captured when it arrived.
    assign w_accept_target = (r_state == ST_PEND) ? r_target : w_new_target;

    assign flush          = w_accept || (r_state == ST_FLUSH);
    assign redirect_valid = w_accept;
    assign redirect_pc    = w_accept ? w_accept_target : r_last_pc;
    assign exc_pending    = (r_state == ST_PEND);
    assign stall_cycles   = r_stall_cycles;

    stall_vector_gen #(
        .STAGES (STAGES)
    ) u_stall_vector_gen (
        .stall_req (stall_req),
        .stall_all (stall_all),
        .flush     (flush),
        .stall     (stall),
        .bubble    (bubble)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_count        <= '0;
            r_target       <= '0;
            r_last_pc      <= INIT_PC;
            r_stall_cycles <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_PEND: begin
                    if ((r_state == ST_IDLE) && w_exc_valid && stall_all) begin
                        r_state  <= ST_PEND;
                        r_target <= w_new_target;
                    end else if (w_accept) begin
                        // The accept cycle is the first flush cycle.
                        if (FLUSH_LEN > 1) begin
                            r_state <= ST_FLUSH;
                            r_count <= CNT_W'(FLUSH_LEN - 1);
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!stall_all) begin
                        r_count <= r_count - 1'b1;
                        if (r_count == CNT_W'(1)) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_accept) begin
                r_last_pc <= w_accept_target;
            end

            if (perf_clr) begin
                r_stall_cycles <= '0;
            end else if (stall[0] && !flush && (r_stall_cycles != 32'hffffffff)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_gen.sv
// ============================================================================
// tb_pipe_ctrl_gen : directed scoreboard bench for pipe_ctrl_gen
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_req;
    logic        stall_all;
    logic [3:0]  exception_type;
    logic [31:0] cp0_epc;
    logic [31:0] exc_base;
    logic        perf_clr;

    logic [5:0]  stall1, bubble1, stall3, bubble3;
    logic        flush1, rv1, pend1, flush3, rv3, pend3;
    logic [31:0] pc1, cyc1, pc3, cyc3;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        int          who;
        logic [5:0]  st;
        logic [5:0]  bu;
        logic        fl;
        logic        rv;
        logic [31:0] pc;
        logic        pe;
        logic [31:0] cy;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_ctrl_gen u_dut1 (
        .clk (clk), .rst (rst), .stall_req (stall_req), .stall_all (stall_all),
        .exception_type (exception_type), .cp0_epc (cp0_epc), .exc_base (exc_base),
        .perf_clr (perf_clr), .stall (stall1), .bubble (bubble1), .flush (flush1),
        .redirect_valid (rv1), .redirect_pc (pc1), .exc_pending (pend1),
        .stall_cycles (cyc1)
    );

    pipe_ctrl_gen #(.FLUSH_LEN (3)) u_dut3 (
        .clk (clk), .rst (rst), .stall_req (stall_req), .stall_all (stall_all),
        .exception_type (exception_type), .cp0_epc (cp0_epc), .exc_base (exc_base),
        .perf_clr (perf_clr), .stall (stall3), .bubble (bubble3), .flush (flush3),
        .redirect_valid (rv3), .redirect_pc (pc3), .exc_pending (pend3),
        .stall_cycles (cyc3)
    );

    task automatic expect_out(input string tag, input int who, input logic [5:0] st,
                              input logic [5:0] bu, input logic fl, input logic rv,
                              input logic [31:0] pc, input logic pe, input logic [31:0] cy);
        exp_t e;
        e.tag = tag; e.who = who; e.st = st; e.bu = bu; e.fl = fl;
        e.rv = rv; e.pc = pc; e.pe = pe; e.cy = cy;
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.who == 3) begin
                chk({e.tag, ".stall"},  {26'd0, stall3},  {26'd0, e.st});
                chk({e.tag, ".bubble"}, {26'd0, bubble3}, {26'd0, e.bu});
                chk({e.tag, ".flush"},  {31'd0, flush3},  {31'd0, e.fl});
                chk({e.tag, ".rv"},     {31'd0, rv3},     {31'd0, e.rv});
                chk({e.tag, ".pc"},     pc3,              e.pc);
                chk({e.tag, ".pend"},   {31'd0, pend3},   {31'd0, e.pe});
                chk({e.tag, ".cyc"},    cyc3,             e.cy);
            end else begin
                chk({e.tag, ".stall"},  {26'd0, stall1},  {26'd0, e.st});
                chk({e.tag, ".bubble"}, {26'd0, bubble1}, {26'd0, e.bu});
                chk({e.tag, ".flush"},  {31'd0, flush1},  {31'd0, e.fl});
                chk({e.tag, ".rv"},     {31'd0, rv1},     {31'd0, e.rv});
                chk({e.tag, ".pc"},     pc1,              e.pc);
                chk({e.tag, ".pend"},   {31'd0, pend1},   {31'd0, e.pe});
                chk({e.tag, ".cyc"},    cyc1,             e.cy);
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; stall_req = '0; stall_all = 1'b0; exception_type = '0;
        cp0_epc = '0; exc_base = '0; perf_clr = 1'b0;
        @(posedge clk); #1;
        expect_out("reset1", 1, 6'b0, 6'b0, 0, 0, 32'hbfc00000, 0, 0);
        expect_out("reset3", 3, 6'b0, 6'b0, 0, 0, 32'hbfc00000, 0, 0);
        cycle();
        rst = 1'b1;

        // Stall vector generation
        stall_req = 6'b000100;
        expect_out("req2", 1, 6'b000111, 6'b001000, 0, 0, 32'hbfc00000, 0, 0);
        cycle();
        stall_req = 6'b001010;
        expect_out("req31", 1, 6'b001111, 6'b010000, 0, 0, 32'hbfc00000, 0, 1);
        cycle();

        // ERET redirect, single-cycle flush on the default instance
        stall_req = '0; exception_type = 4'd1; cp0_epc = 32'h80001234;
        expect_out("eret", 1, 6'b0, 6'b0, 1, 1, 32'h80001234, 0, 2);
        cycle();
        exception_type = 4'd0;
        expect_out("eret_after", 1, 6'b0, 6'b0, 0, 0, 32'h80001234, 0, 2);
        cycle();
        cycle();

        // Exception deferred by a three-cycle freeze
        exception_type = 4'd5; exc_base = 32'hbfc00200; stall_all = 1'b1;
        expect_out("defer0", 1, 6'b111111, 6'b0, 0, 0, 32'h80001234, 0, 2);
        cycle();
        exception_type = 4'd1;
        expect_out("defer1", 1, 6'b111111, 6'b0, 0, 0, 32'h80001234, 1, 3);
        cycle();
        expect_out("defer2", 1, 6'b111111, 6'b0, 0, 0, 32'h80001234, 1, 4);
        cycle();
        stall_all = 1'b0; exception_type = 4'd0;
        expect_out("release", 1, 6'b0, 6'b0, 1, 1, 32'hbfc00380, 1, 5);
        cycle();
        expect_out("release_after", 1, 6'b0, 6'b0, 0, 0, 32'hbfc00380, 0, 5);
        cycle();
        cycle();

        // Three-cycle flush stretched by one frozen cycle
        exception_type = 4'd1; cp0_epc = 32'h80005678;
        expect_out("fl3_0", 3, 6'b0, 6'b0, 1, 1, 32'h80005678, 0, 5);
        cycle();
        exception_type = 4'd5; stall_req = 6'b000100;
        expect_out("fl3_1", 3, 6'b0, 6'b0, 1, 0, 32'h80005678, 0, 5);
        cycle();
        stall_all = 1'b1;
        expect_out("fl3_frz", 3, 6'b111111, 6'b0, 1, 0, 32'h80005678, 0, 5);
        cycle();
        stall_all = 1'b0;
        expect_out("fl3_2", 3, 6'b0, 6'b0, 1, 0, 32'h80005678, 0, 5);
        cycle();
        exception_type = 4'd0; stall_req = '0;
        expect_out("fl3_done", 3, 6'b0, 6'b0, 0, 0, 32'h80005678, 0, 5);
        cycle();

        // Counter saturation and clear
        stall_req = 6'b000001;
        force u_dut1.r_stall_cycles = 32'hfffffffe;
        expect_out("sat_force", 1, 6'b000001, 6'b000010, 0, 0, 32'hbfc00380, 0, 32'hfffffffe);
        cycle();
        release u_dut1.r_stall_cycles;
        cycle();
        expect_out("sat_a", 1, 6'b000001, 6'b000010, 0, 0, 32'hbfc00380, 0, 32'hffffffff);
        cycle();
        expect_out("sat_b", 1, 6'b000001, 6'b000010, 0, 0, 32'hbfc00380, 0, 32'hffffffff);
        cycle();
        perf_clr = 1'b1;
        expect_out("clr_in", 1, 6'b000001, 6'b000010, 0, 0, 32'hbfc00380, 0, 32'hffffffff);
        cycle();
        perf_clr = 1'b0; stall_req = '0;
        expect_out("clr_out", 1, 6'b0, 6'b0, 0, 0, 32'hbfc00380, 0, 0);
        cycle();

        // Asynchronous reset while the long-flush instance is mid-flush
        exception_type = 4'd1; cp0_epc = 32'h8000abcd;
        expect_out("rf_acc", 3, 6'b0, 6'b0, 1, 1, 32'h8000abcd, 0, 0);
        cycle();
        exception_type = 4'd0;
        rst = 1'b0;
        #1;
        expect_out("rst_mid3", 3, 6'b0, 6'b0, 0, 0, 32'hbfc00000, 0, 0);
        expect_out("rst_mid1", 1, 6'b0, 6'b0, 0, 0, 32'hbfc00000, 0, 0);
        compare_all();
        @(posedge clk); #1;
        rst = 1'b1;
        expect_out("post_rst", 3, 6'b0, 6'b0, 0, 0, 32'hbfc00000, 0, 0);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
